// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM states, default widths,
// latency-counter width and the captured response-flag payload.
package mem_responder_pkg;

  localparam int unsigned DATA_W_DEF     = 16;
  localparam int unsigned ADDR_W_DEF     = 16;
  localparam int unsigned DEPTH_LOG2_DEF = 10;
  localparam int unsigned LATENCY_DEF    = 2;
  localparam int unsigned CNT_W          = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Flags captured at accept and presented with the response
  typedef struct packed {
    logic write;
    logic err;
  } rsp_flags_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the datapath (master) and the memory
// responder (slave): valid/ready request channel plus held response channel.
interface mem_responder_if
  import mem_responder_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_write;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_write, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_write, rsp_err
  );

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous RAM with registered read port. A write returns its
// own data on the read port so the response path never needs a bypass mux.
module mem_array #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is never cleared so contents survive reset
  always_ff @(posedge clock) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= we ? wdata : mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: accepts requests, services them from
// mem_array and holds the response until taken. MEM_BOUNDS_EN enables rsp_err.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int unsigned LATENCY    = LATENCY_DEF
) (
  input  logic           clock,
  input  logic           reset_n,
  mem_responder_if.slave bus
);

  state_e            state, state_next;
  logic [CNT_W-1:0]  count, count_next;
  logic              rsp_valid_q, rsp_valid_next;
  rsp_flags_t        flags, flags_next;
  logic              req_ready_c;
  logic              accept;
  logic              out_of_range;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

`ifdef MEM_BOUNDS_EN
  assign out_of_range = (bus.req_addr >> DEPTH_LOG2) != '0;
`else
  assign out_of_range = 1'b0;
`endif

  // Ready in IDLE, or in RESP only when the held response is being taken
  always_comb begin
    req_ready_c = 1'b0;
    if (reset_n) begin
      case (state)
        IDLE:    req_ready_c = 1'b1;
        RESP:    req_ready_c = bus.rsp_ready;
        default: req_ready_c = 1'b0;
      endcase
    end
  end

  assign accept = bus.req_valid & req_ready_c;
  assign ram_we = bus.req_write & ~out_of_range;

  always_comb begin
    state_next     = state;
    count_next     = count;
    rsp_valid_next = rsp_valid_q;
    flags_next     = flags;
    case (state)
      IDLE: ;
      WAIT: begin
        count_next = count - CNT_W'(1);
        if (count == CNT_W'(1)) begin
          state_next     = RESP;
          rsp_valid_next = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_next     = IDLE;
          rsp_valid_next = 1'b0;
        end
      end
      default: begin
        state_next     = IDLE;
        rsp_valid_next = 1'b0;
      end
    endcase
    // A new accept overrides, whether from IDLE or back-to-back from RESP
    if (accept) begin
      flags_next.write = bus.req_write;
      flags_next.err   = out_of_range;
      if (LATENCY == 1) begin
        state_next     = RESP;
        rsp_valid_next = 1'b1;
        count_next     = '0;
      end else begin
        state_next     = WAIT;
        rsp_valid_next = 1'b0;
        count_next     = CNT_W'(LATENCY - 1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      count       <= '0;
      rsp_valid_q <= 1'b0;
      flags       <= '0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      rsp_valid_q <= rsp_valid_next;
      flags       <= flags_next;
    end
  end

  mem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (accept),
    .we      (ram_we),
    .addr    (bus.req_addr[DEPTH_LOG2-1:0]),
    .wdata   (bus.req_wdata),
    .rdata   (ram_rdata)
  );

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = flags.write;
  assign bus.rsp_err   = flags.err;
  assign bus.rsp_rdata = flags.err ? '0 : ram_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: LATENCY=2 instance for the main scenarios
// and a LATENCY=1 instance for single-cycle streaming.
module tb_mem_responder;

  logic clock = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  mem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus  ();
  mem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus1 ();

  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .LATENCY(2)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus));

  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .LATENCY(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(bus1));

  task automatic tick();
    @(negedge clock);
  endtask

  // Present one request at a negedge; it is accepted on the following posedge
  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Cycles from the accept edge until rsp_valid is seen (bounded)
  task automatic await_rsp(output int cycles);
    cycles = 1;
    while (bus.rsp_valid !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  task automatic do_txn(input logic w, input logic [15:0] a, input logic [15:0] d);
    int c;
    bus.rsp_ready = 1'b1;
    issue(w, a, d);
    await_rsp(c);
    tick();
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    bus.req_valid  = 1'b0; bus.req_write  = 1'b0; bus.req_addr  = '0; bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
    bus1.rsp_ready = 1'b0;
    repeat (3) tick();
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid); end
    total++; if (bus.rsp_rdata !== 16'h0) begin bad++; $display("FAIL reset_rsp_rdata got=%h want=0000", bus.rsp_rdata); end
    total++; if (bus.rsp_write !== 1'b0) begin bad++; $display("FAIL reset_rsp_write got=%b want=0", bus.rsp_write); end
    total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b want=0", bus.rsp_err); end
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b want=0", bus.req_ready); end
    total++; if (bus1.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_l1_rsp_valid got=%b want=0", bus1.rsp_valid); end
    reset_n = 1'b1;
    #1;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL idle_req_ready got=%b want=1", bus.req_ready); end
    tick();
  endtask

  task automatic test_write_read();
    int c;
    bus.rsp_ready = 1'b1;
    issue(1'b1, 16'h0001, 16'd127);
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_early_valid got=%b want=0", bus.rsp_valid); end
    await_rsp(c);
    total++; if (c !== 2) begin bad++; $display("FAIL wr_latency got=%0d want=2", c); end
    total++; if (bus.rsp_write !== 1'b1) begin bad++; $display("FAIL wr_rsp_write got=%b want=1", bus.rsp_write); end
    total++; if (bus.rsp_rdata !== 16'd127) begin bad++; $display("FAIL wr_echo got=%h want=007f", bus.rsp_rdata); end
    tick();
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_release got=%b want=0", bus.rsp_valid); end
    issue(1'b0, 16'h0001, 16'h0);
    await_rsp(c);
    total++; if (c !== 2) begin bad++; $display("FAIL rd_latency got=%0d want=2", c); end
    total++; if (bus.rsp_write !== 1'b0) begin bad++; $display("FAIL rd_rsp_write got=%b want=0", bus.rsp_write); end
    total++; if (bus.rsp_rdata !== 16'd127) begin bad++; $display("FAIL rd_data got=%h want=007f", bus.rsp_rdata); end
    tick();
  endtask

  task automatic test_hold();
    int c;
    bus.rsp_ready = 1'b0;
    issue(1'b0, 16'h0001, 16'h0);
    await_rsp(c);
    total++; if (c !== 2) begin bad++; $display("FAIL hold_latency got=%0d want=2", c); end
    // A competing request must be ignored while the response is held
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 16'h0002; bus.req_wdata = 16'hDEAD;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d] got=%b want=1", i, bus.rsp_valid); end
      total++; if (bus.rsp_rdata !== 16'd127) begin bad++; $display("FAIL hold_data[%0d] got=%h want=007f", i, bus.rsp_rdata); end
      total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL hold_req_ready[%0d] got=%b want=0", i, bus.req_ready); end
      tick();
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL hold_release_valid got=%b want=0", bus.rsp_valid); end
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL hold_release_idle got=%b want=1", bus.req_ready); end
  endtask

  task automatic test_back_to_back();
    do_txn(1'b1, 16'h0002, 16'h2222);
    do_txn(1'b1, 16'h0003, 16'h3333);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 16'h0002;
    tick();
    bus.req_addr = 16'h0003;
    #1;
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL b2b_wait_ready got=%b want=0", bus.req_ready); end
    tick();
    #1;
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL b2b_first_valid got=%b want=1", bus.rsp_valid); end
    total++; if (bus.rsp_rdata !== 16'h2222) begin bad++; $display("FAIL b2b_first_data got=%h want=2222", bus.rsp_rdata); end
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL b2b_resp_ready got=%b want=1", bus.req_ready); end
    tick();
    bus.req_valid = 1'b0;
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_gap_valid got=%b want=0", bus.rsp_valid); end
    tick();
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL b2b_second_valid got=%b want=1", bus.rsp_valid); end
    total++; if (bus.rsp_rdata !== 16'h3333) begin bad++; $display("FAIL b2b_second_data got=%h want=3333", bus.rsp_rdata); end
    tick();
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_end_valid got=%b want=0", bus.rsp_valid); end
  endtask

  task automatic test_wrap();
    int c;
    logic        exp_err;
    logic [15:0] exp_echo, exp_five;
`ifdef MEM_BOUNDS_EN
    exp_err = 1'b1; exp_echo = 16'h0000; exp_five = 16'h0555;
`else
    exp_err = 1'b0; exp_echo = 16'hBEEF; exp_five = 16'hBEEF;
`endif
    do_txn(1'b1, 16'h0005, 16'h0555);
    bus.rsp_ready = 1'b1;
    issue(1'b1, 16'h0405, 16'hBEEF);
    await_rsp(c);
    total++; if (c !== 2) begin bad++; $display("FAIL wrap_latency got=%0d want=2", c); end
    total++; if (bus.rsp_err !== exp_err) begin bad++; $display("FAIL wrap_err got=%b want=%b", bus.rsp_err, exp_err); end
    total++; if (bus.rsp_rdata !== exp_echo) begin bad++; $display("FAIL wrap_echo got=%h want=%h", bus.rsp_rdata, exp_echo); end
    tick();
    issue(1'b0, 16'h0005, 16'h0);
    await_rsp(c);
    total++; if (bus.rsp_rdata !== exp_five) begin bad++; $display("FAIL wrap_read5 got=%h want=%h", bus.rsp_rdata, exp_five); end
    total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL wrap_read5_err got=%b want=0", bus.rsp_err); end
    tick();
  endtask

  task automatic test_reset_mid();
    int c;
    bus.rsp_ready = 1'b1;
    issue(1'b1, 16'h0007, 16'h7777);
    reset_n = 1'b0;
    tick();
    #1;
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", bus.rsp_valid); end
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL rstmid_ready got=%b want=0", bus.req_ready); end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rstmid_after[%0d] got=%b want=0", i, bus.rsp_valid); end
    end
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rstmid_idle got=%b want=1", bus.req_ready); end
    issue(1'b0, 16'h0001, 16'h0);
    await_rsp(c);
    total++; if (bus.rsp_rdata !== 16'd127) begin bad++; $display("FAIL rstmid_addr1 got=%h want=007f", bus.rsp_rdata); end
    tick();
    issue(1'b0, 16'h0007, 16'h0);
    await_rsp(c);
    total++; if (bus.rsp_rdata !== 16'h7777) begin bad++; $display("FAIL rstmid_addr7 got=%h want=7777", bus.rsp_rdata); end
    tick();
  endtask

  task automatic test_latency1();
    logic [15:0] exp_d;
    logic        exp_w;
    bus1.rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_w = (i < 4);
      exp_d = 16'hA000 + 16'(i % 4);
      bus1.req_valid = 1'b1;
      bus1.req_write = exp_w;
      bus1.req_addr  = 16'(20 + (i % 4));
      bus1.req_wdata = exp_d;
      tick();
      total++; if (bus1.rsp_valid !== 1'b1) begin bad++; $display("FAIL l1_valid[%0d] got=%b want=1", i, bus1.rsp_valid); end
      total++; if (bus1.rsp_rdata !== exp_d) begin bad++; $display("FAIL l1_data[%0d] got=%h want=%h", i, bus1.rsp_rdata, exp_d); end
      total++; if (bus1.rsp_write !== exp_w) begin bad++; $display("FAIL l1_write[%0d] got=%b want=%b", i, bus1.rsp_write, exp_w); end
      total++; if (bus1.req_ready !== 1'b1) begin bad++; $display("FAIL l1_ready[%0d] got=%b want=1", i, bus1.req_ready); end
    end
    bus1.req_valid = 1'b0;
    tick();
    total++; if (bus1.rsp_valid !== 1'b0) begin bad++; $display("FAIL l1_end_valid got=%b want=0", bus1.rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_hold();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_latency1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
